ysyx_22041412_icache_ctrl: RTL and testbench

Direct-mapped instruction-cache controller that sits directly upstream of the 64-bit cache data SRAM and drives both of its ports. Holds tag and valid arrays in flops and answers fetch requests from the IFU. On a miss it fetches one 64-bit line over a simple request/response memory bus, writes the line into the SRAM and forwards the requested word.

---
 rtl/ysyx_22041412_icache_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_ysyx_22041412_icache_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041412_icache_ctrl.sv
// Direct-mapped instruction-cache controller.
// Keeps tag/valid state in flops and drives both ports of an external 64-bit
// line SRAM. Misses fetch one 8-byte line over a request/response memory bus;
// the requested word is bypassed to the fetch unit in the fill cycle.
// Optional feature macro: YSYX_22041412_ICACHE_PERF_EN adds hit/miss counters.
module ysyx_22041412_icache_ctrl #(
    parameter int INDEX_W = 6,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_req_valid,
    output logic               cpu_req_ready,
    input  logic [ADDR_W-1:0]  cpu_addr,
    output logic               cpu_resp_valid,
    output logic [31:0]        cpu_resp_data,
    input  logic               flush,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_resp_valid,
    input  logic [63:0]        mem_resp_data,
    output logic [INDEX_W-1:0] sram_addr_r,
    output logic               sram_read_en,
    input  logic [63:0]        sram_data_r,
    output logic [INDEX_W-1:0] sram_addr_w,
    output logic               sram_wead_en,
    output logic [63:0]        sram_data_w
`ifdef YSYX_22041412_ICACHE_PERF_EN
    ,
    output logic [31:0]        perf_hit_cnt,
    output logic [31:0]        perf_miss_cnt
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W - 3;
    localparam int LINES = 2 ** INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        MISS_REQ  = 2'd2,
        MISS_WAIT = 2'd3
    } state_t;

    state_t             state_r;
    logic [ADDR_W-1:2]  addr_r;
    logic [LINES-1:0]   valid_r;
    logic [TAG_W-1:0]   tag_arr_r [LINES];
    logic               flush_pending_r;
    logic               resp_valid_r;
    logic [31:0]        resp_data_r;

    logic [INDEX_W-1:0] req_idx_s;
    logic [INDEX_W-1:0] cur_idx_s;
    logic [TAG_W-1:0]   cur_tag_s;
    logic               accept_s;
    logic               line_match_s;
    logic               refill_s;
    logic               flush_clear_s;
    logic               unused_addr_bits_s;

    // Pick the 32-bit instruction out of a 64-bit line using address bit 2.
    function automatic logic [31:0] sel_word(input logic [63:0] line, input logic hi);
        logic [31:0] w;
        if (hi) begin
            w = line[63:32];
        end else begin
            w = line[31:0];
        end
        return w;
    endfunction

    assign req_idx_s          = cpu_addr[INDEX_W+2:3];
    assign cur_idx_s          = addr_r[INDEX_W+2:3];
    assign cur_tag_s          = addr_r[ADDR_W-1:INDEX_W+3];
    assign unused_addr_bits_s = ^cpu_addr[1:0];

    // Decode the per-cycle events that steer both the FSM and the SRAM ports.
    always_comb begin
        accept_s      = 1'b0;
        line_match_s  = 1'b0;
        refill_s      = 1'b0;
        flush_clear_s = 1'b0;
        if (state_r == IDLE) begin
            flush_clear_s = flush || flush_pending_r;
            accept_s      = cpu_req_valid && !flush && !flush_pending_r;
        end else begin
            flush_clear_s = 1'b0;
            accept_s      = 1'b0;
        end
        if (valid_r[cur_idx_s] && (tag_arr_r[cur_idx_s] == cur_tag_s)) begin
            line_match_s = 1'b1;
        end else begin
            line_match_s = 1'b0;
        end
        if ((state_r == MISS_WAIT) && mem_resp_valid) begin
            refill_s = 1'b1;
        end else begin
            refill_s = 1'b0;
        end
    end

    // Drive the CPU, memory and SRAM ports; enables are single-cycle pulses.
    always_comb begin
        cpu_req_ready  = (state_r == IDLE) && !flush && !flush_pending_r;
        mem_req_valid  = (state_r == MISS_REQ);
        mem_req_addr   = {addr_r[ADDR_W-1:3], 3'b000};
        sram_read_en   = accept_s;
        sram_wead_en   = refill_s;
        cpu_resp_valid = resp_valid_r || refill_s;
        if (accept_s) begin
            sram_addr_r = req_idx_s;
        end else begin
            sram_addr_r = {INDEX_W{1'b0}};
        end
        if (refill_s) begin
            sram_addr_w   = cur_idx_s;
            sram_data_w   = mem_resp_data;
            cpu_resp_data = sel_word(mem_resp_data, addr_r[2]);
        end else begin
            sram_addr_w   = {INDEX_W{1'b0}};
            sram_data_w   = 64'h0;
            cpu_resp_data = resp_data_r;
        end
    end

    // Main controller FSM: lookup, line-fill handshake, tag/valid update, flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            addr_r          <= '0;
            valid_r         <= '0;
            flush_pending_r <= 1'b0;
            resp_valid_r    <= 1'b0;
            resp_data_r     <= 32'h0;
            for (int i = 0; i < LINES; i++) begin
                tag_arr_r[i] <= '0;
            end
        end else begin
            resp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (flush_clear_s) begin
                        valid_r         <= '0;
                        flush_pending_r <= 1'b0;
                    end else if (accept_s) begin
                        addr_r  <= cpu_addr[ADDR_W-1:2];
                        state_r <= LOOKUP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOOKUP: begin
                    if (line_match_s) begin
                        resp_valid_r <= 1'b1;
                        resp_data_r  <= sel_word(sram_data_r, addr_r[2]);
                        state_r      <= IDLE;
                    end else begin
                        state_r <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (mem_req_ready) begin
                        state_r <= MISS_WAIT;
                    end else begin
                        state_r <= MISS_REQ;
                    end
                end
                MISS_WAIT: begin
                    if (mem_resp_valid) begin
                        valid_r[cur_idx_s]   <= 1'b1;
                        tag_arr_r[cur_idx_s] <= cur_tag_s;
                        resp_data_r          <= sel_word(mem_resp_data, addr_r[2]);
                        state_r              <= IDLE;
                    end else begin
                        state_r <= MISS_WAIT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
            // A flush seen mid-transaction is deferred to the next IDLE cycle.
            if (flush && (state_r != IDLE)) begin
                flush_pending_r <= 1'b1;
            end else begin
                flush_pending_r <= flush_pending_r && !flush_clear_s;
            end
        end
    end

`ifdef YSYX_22041412_ICACHE_PERF_EN
    // Count lookup outcomes; counters wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hit_cnt  <= 32'h0;
            perf_miss_cnt <= 32'h0;
        end else if (state_r == LOOKUP) begin
            if (line_match_s) begin
                perf_hit_cnt <= perf_hit_cnt + 32'd1;
            end else begin
                perf_miss_cnt <= perf_miss_cnt + 32'd1;
            end
        end else begin
            perf_hit_cnt  <= perf_hit_cnt;
            perf_miss_cnt <= perf_miss_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22041412_icache_ctrl.sv
// Self-checking bench for ysyx_22041412_icache_ctrl: directed vector table,
// hand-written flush/reset sequences, and randomized fetches checked against
// a line-level cache model (set of resident line addresses).
module tb_ysyx_22041412_icache_ctrl;

    localparam int IW = 6;
    localparam int AW = 32;

    logic          clk;
    logic          rst_n;
    logic          cpu_req_valid;
    logic          cpu_req_ready;
    logic [AW-1:0] cpu_addr;
    logic          cpu_resp_valid;
    logic [31:0]   cpu_resp_data;
    logic          flush;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_resp_valid;
    logic [63:0]   mem_resp_data;
    logic [IW-1:0] sram_addr_r;
    logic          sram_read_en;
    logic [63:0]   sram_data_r;
    logic [IW-1:0] sram_addr_w;
    logic          sram_wead_en;
    logic [63:0]   sram_data_w;
`ifdef YSYX_22041412_ICACHE_PERF_EN
    logic [31:0]   perf_hit_cnt;
    logic [31:0]   perf_miss_cnt;
`endif

    int nvec;
    int nmis;
    int hits_m;
    int misses_m;

    ysyx_22041412_icache_ctrl #(.INDEX_W(IW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_addr(cpu_addr),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .sram_addr_r(sram_addr_r), .sram_read_en(sram_read_en), .sram_data_r(sram_data_r),
        .sram_addr_w(sram_addr_w), .sram_wead_en(sram_wead_en), .sram_data_w(sram_data_w)
`ifdef YSYX_22041412_ICACHE_PERF_EN
        , .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural line SRAM: registered read, synchronous write.
    logic [63:0] sram_mem [0:63];
    always @(posedge clk) begin
        if (sram_wead_en) sram_mem[sram_addr_w] <= sram_data_w;
        if (sram_read_en) sram_data_r <= sram_mem[sram_addr_r];
    end

    // Reference model: resident lines keyed by 8-byte-aligned line address.
    logic [63:0] cached [logic [31:0]];

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return {a[31:3], 3'b000};
    endfunction

    function automatic logic [31:0] word_of(input logic [63:0] line, input logic [31:0] a);
        logic [31:0] w;
        w = a[2] ? line[63:32] : line[31:0];
        return w;
    endfunction

    function automatic logic [63:0] mem_line(input logic [31:0] la);
        return {la ^ 32'hC3C3_5A5A, ~la};
    endfunction

    task automatic model_fill(input logic [31:0] la, input logic [63:0] line);
        logic [31:0] victims [$];
        foreach (cached[k]) begin
            if (((k >> 3) % 64) == ((la >> 3) % 64)) victims.push_back(k);
        end
        foreach (victims[j]) cached.delete(victims[j]);
        cached[la] = line;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One fetch transaction; starts just after a falling edge and ends on one.
    task automatic fetch(input logic [31:0] a, input logic [63:0] line, input int stall,
                         input int rdelay, input bit flush_wait,
                         output bit miss, output logic [31:0] data, output int lat,
                         output logic [31:0] maddr);
        bit acc, hs, done;
        int acc_i, hs_i, st;
        acc = 0; hs = 0; done = 0; acc_i = 0; hs_i = 0; st = stall;
        miss = 0; data = 32'h0; lat = -1; maddr = 32'h0;
        for (int i = 0; i < 100 && !done; i++) begin
            cpu_req_valid  = !acc;
            cpu_addr       = a;
            mem_req_ready  = 1'b0;
            flush          = flush_wait && hs && (i == hs_i + 1);
            mem_resp_valid = hs && (i == hs_i + 1 + rdelay);
            mem_resp_data  = mem_resp_valid ? line : 64'h0;
            #1;
            chk("sram_en_exclusive", {63'h0, sram_read_en & sram_wead_en}, 64'h0);
            if (hs && i == hs_i + 1) chk("req_valid_dropped", {63'h0, mem_req_valid}, 64'h0);
            if (!acc && cpu_req_ready) begin
                acc = 1; acc_i = i;
                chk("sram_read_en", {63'h0, sram_read_en}, 64'h1);
                chk("sram_addr_r", {58'h0, sram_addr_r}, {58'h0, a[8:3]});
            end
            if (mem_req_valid && !hs) begin
                if (!miss) begin
                    miss = 1; maddr = mem_req_addr;
                end else begin
                    chk("req_addr_stable", {32'h0, mem_req_addr}, {32'h0, maddr});
                    chk("ready_in_stall", {63'h0, cpu_req_ready}, 64'h0);
                    chk("no_resp_in_stall", {63'h0, cpu_resp_valid}, 64'h0);
                end
                if (st == 0) begin
                    mem_req_ready = 1'b1; hs = 1; hs_i = i;
                end else begin
                    st--;
                end
            end
            if (cpu_resp_valid) begin
                data = cpu_resp_data; lat = i - acc_i; done = 1;
                if (miss) begin
                    chk("sram_wead_en", {63'h0, sram_wead_en}, 64'h1);
                    chk("sram_addr_w", {58'h0, sram_addr_w}, {58'h0, a[8:3]});
                    chk("sram_data_w", sram_data_w, line);
                end
            end
            @(negedge clk);
        end
        cpu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_data = 64'h0; flush = 1'b0;
        if (!done) chk("fetch_timeout", 64'h0, 64'h1);
    endtask

    task automatic idle_flush(input logic [31:0] a);
        flush = 1'b1; cpu_req_valid = 1'b1; cpu_addr = a;
        #1;
        chk("flush_blocks_ready", {63'h0, cpu_req_ready}, 64'h0);
        chk("flush_no_read", {63'h0, sram_read_en}, 64'h0);
        @(negedge clk);
        flush = 1'b0; cpu_req_valid = 1'b0;
        cached.delete();
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [63:0] line;
        int          stall;
        int          rdelay;
        bit          exp_miss;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vt [11];
    bit          miss;
    logic [31:0] data;
    int          lat;
    logic [31:0] maddr;
    logic [31:0] ra;
    logic [31:0] rla;
    logic [63:0] rline;
    bit          exp_hit;
    bit          fw;
    bit          seen;

    initial begin
        nvec = 0; nmis = 0; hits_m = 0; misses_m = 0;
        rst_n = 1'b0; cpu_req_valid = 1'b0; cpu_addr = 32'h0; flush = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 64'h0;

        vt[0]  = '{32'h8000_0004, 64'h1111_2222_3333_4444, 0, 0, 1'b1, 32'h1111_2222};
        vt[1]  = '{32'h8000_0000, 64'h0,                   0, 0, 1'b0, 32'h3333_4444};
        vt[2]  = '{32'h8000_0200, 64'hAAAA_BBBB_CCCC_DDDD, 5, 1, 1'b1, 32'hCCCC_DDDD};
        vt[3]  = '{32'h8000_0204, 64'h0,                   0, 0, 1'b0, 32'hAAAA_BBBB};
        vt[4]  = '{32'h8000_0000, 64'h1111_2222_3333_4444, 0, 2, 1'b1, 32'h3333_4444};
        vt[5]  = '{32'h8000_0008, 64'h5555_6666_7777_8888, 1, 0, 1'b1, 32'h7777_8888};
        vt[6]  = '{32'h8000_000C, 64'h0,                   0, 0, 1'b0, 32'h5555_6666};
        vt[7]  = '{32'h8000_01F8, 64'h0123_4567_89AB_CDEF, 0, 3, 1'b1, 32'h89AB_CDEF};
        vt[8]  = '{32'h8000_01FC, 64'h0,                   0, 0, 1'b0, 32'h0123_4567};
        vt[9]  = '{32'h8000_0006, 64'h0,                   0, 0, 1'b0, 32'h1111_2222};
        vt[10] = '{32'h8000_0202, 64'hAAAA_BBBB_CCCC_DDDD, 2, 0, 1'b1, 32'hCCCC_DDDD};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", {63'h0, cpu_req_ready}, 64'h1);
        chk("rst_resp_valid", {63'h0, cpu_resp_valid}, 64'h0);
        chk("rst_resp_data", {32'h0, cpu_resp_data}, 64'h0);
        chk("rst_mem_req", {63'h0, mem_req_valid}, 64'h0);
        chk("rst_mem_addr", {32'h0, mem_req_addr}, 64'h0);
        chk("rst_sram_en", {62'h0, sram_read_en, sram_wead_en}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table.
        for (int v = 0; v < 11; v++) begin
            fetch(vt[v].addr, vt[v].line, vt[v].stall, vt[v].rdelay, 1'b0, miss, data, lat, maddr);
            chk("vec_miss", {63'h0, miss}, {63'h0, vt[v].exp_miss});
            chk("vec_data", {32'h0, data}, {32'h0, vt[v].exp_data});
            if (vt[v].exp_miss) begin
                chk("vec_mem_addr", {32'h0, maddr}, {32'h0, line_of(vt[v].addr)});
                model_fill(line_of(vt[v].addr), vt[v].line);
                misses_m++;
            end else begin
                chk("vec_hit_latency", lat, 64'd2);
                hits_m++;
            end
        end

        // Flush during MISS_WAIT: refill responds, next IDLE not ready, line gone.
        idle_flush(32'h8000_0104);
        rline = 64'hFEED_0001_BEEF_0002;
        fetch(32'h8000_0104, rline, 0, 2, 1'b1, miss, data, lat, maddr);
        chk("fw_miss", {63'h0, miss}, 64'h1);
        chk("fw_data", {32'h0, data}, 64'hFEED_0001);
        misses_m++;
        #1;
        chk("fw_ready_low", {63'h0, cpu_req_ready}, 64'h0);
        @(negedge clk);
        cached.delete();
        fetch(32'h8000_0104, rline, 0, 0, 1'b0, miss, data, lat, maddr);
        chk("fw_remiss", {63'h0, miss}, 64'h1);
        chk("fw_redata", {32'h0, data}, 64'hFEED_0001);
        model_fill(32'h8000_0100, rline);
        misses_m++;

        // Randomized fetches against the line-level model.
        for (int n = 0; n < 150; n++) begin
            ra = 32'h8000_0000 | ($urandom_range(0, 3) << 9) | ($urandom_range(0, 63) << 3)
                 | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
            rla = line_of(ra);
            if ($urandom_range(0, 9) == 0) idle_flush(ra);
            exp_hit = cached.exists(rla);
            rline = exp_hit ? cached[rla] : mem_line(rla);
            fw = ($urandom_range(0, 11) == 0);
            fetch(ra, mem_line(rla), $urandom_range(0, 3), $urandom_range(0, 3), fw,
                  miss, data, lat, maddr);
            chk("rnd_miss", {63'h0, miss}, {63'h0, !exp_hit});
            chk("rnd_data", {32'h0, data}, {32'h0, word_of(rline, ra)});
            if (exp_hit) begin
                chk("rnd_hit_latency", lat, 64'd2);
                hits_m++;
            end else begin
                chk("rnd_mem_addr", {32'h0, maddr}, {32'h0, rla});
                model_fill(rla, rline);
                misses_m++;
                if (fw) begin
                    #1;
                    chk("rnd_fw_ready_low", {63'h0, cpu_req_ready}, 64'h0);
                    cached.delete();
                end
            end
        end

`ifdef YSYX_22041412_ICACHE_PERF_EN
        chk("perf_hits", {32'h0, perf_hit_cnt}, hits_m);
        chk("perf_misses", {32'h0, perf_miss_cnt}, misses_m);
`endif

        // Reset asserted while the controller is in MISS_REQ.
        @(negedge clk);
        idle_flush(32'h8000_0300);
        fetch(32'h8000_0000, 64'h1111_2222_3333_4444, 0, 0, 1'b0, miss, data, lat, maddr);
        chk("pre_rst_data", {32'h0, data}, 64'h3333_4444);
        cpu_req_valid = 1'b1; cpu_addr = 32'h8000_0300;
        #1;
        chk("rst_seq_accept", {63'h0, cpu_req_ready}, 64'h1);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            cpu_req_valid = 1'b0;
            #1;
            seen = mem_req_valid;
        end
        chk("rst_seq_reached_miss", {63'h0, seen}, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req_valid", {63'h0, mem_req_valid}, 64'h0);
        chk("rst_mid_ready", {63'h0, cpu_req_ready}, 64'h1);
`ifdef YSYX_22041412_ICACHE_PERF_EN
        chk("rst_perf_hits", {32'h0, perf_hit_cnt}, 64'h0);
        chk("rst_perf_misses", {32'h0, perf_miss_cnt}, 64'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cached.delete();
        mem_resp_valid = 1'b1; mem_resp_data = 64'h0BAD_0BAD_0BAD_0BAD;
        #1;
        chk("stale_resp_ignored", {63'h0, cpu_resp_valid}, 64'h0);
        chk("stale_no_write", {63'h0, sram_wead_en}, 64'h0);
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_resp_data = 64'h0;
        #1;
        chk("stale_resp_later", {63'h0, cpu_resp_valid}, 64'h0);
        @(negedge clk);
        fetch(32'h8000_0000, 64'h1111_2222_3333_4444, 0, 1, 1'b0, miss, data, lat, maddr);
        chk("post_rst_miss", {63'h0, miss}, 64'h1);
        chk("post_rst_data", {32'h0, data}, 64'h3333_4444);
        chk("post_rst_mem_addr", {32'h0, maddr}, 64'h8000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
